// File: rtl/frame_tx_scheduler.sv
// Frame transmit scheduler: round-robin arbitration among four requesters,
// byte-serial frame transfer with a valid/ready handshake, parity
// generation, abort handling and a configurable inter-frame gap.
module frame_tx_scheduler #(
  parameter int FRAME_LEN  = 16,
  parameter int GAP_CYCLES = 2,
  parameter int ODD_PARITY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic        abort,
  output logic [3:0]  grant,
  output logic [3:0]  byte_idx,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [8:0]  tx_data,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic [3:0]  done,
  output logic        aborted,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam state_t     END_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;
  localparam logic       PAR_INV   = (ODD_PARITY != 0);

  state_t      state, state_n;
  logic [3:0]  grant_n, idx_n, gap_cnt, gap_n, done_n;
  logic [1:0]  rr_ptr, ptr_n, gsel, gsel_n, win, idx_try;
  logic        win_vld, aborted_n;
  logic [7:0]  cur_byte;

  // Round-robin winner: first requesting lane at or after rr_ptr.
  // Scanning offsets high-to-low lets the lowest offset overwrite last.
  always_comb begin
    win_vld = 1'b0;
    win     = rr_ptr;
    idx_try = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx_try = rr_ptr + 2'(k);
      if (req[idx_try]) begin
        win_vld = 1'b1;
        win     = idx_try;
      end
    end
  end

  // Next-state and next-register values for the IDLE/SEND/GAP sequencer.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    idx_n     = byte_idx;
    gap_n     = gap_cnt;
    ptr_n     = rr_ptr;
    gsel_n    = gsel;
    done_n    = 4'd0;
    aborted_n = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n = SEND;
          grant_n = 4'b0001 << win;
          gsel_n  = win;
          ptr_n   = win + 2'd1;   // pointer moves at grant time, so aborts advance it too
          idx_n   = 4'd0;
        end
      end
      SEND: begin
        if (abort) begin
          aborted_n = 1'b1;
          grant_n   = 4'd0;
          idx_n     = 4'd0;
          gap_n     = GAP_LOAD;
          state_n   = END_STATE;
        end else if (tx_ready) begin
          if (byte_idx == LAST_IDX) begin
            done_n  = grant;
            grant_n = 4'd0;
            idx_n   = 4'd0;
            gap_n   = GAP_LOAD;
            state_n = END_STATE;
          end else begin
            idx_n = byte_idx + 4'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) state_n = IDLE;
        else                 gap_n   = gap_cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 4'd0;
      byte_idx <= 4'd0;
      gap_cnt  <= 4'd0;
      rr_ptr   <= 2'd0;
      gsel     <= 2'd0;
      done     <= 4'd0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      byte_idx <= idx_n;
      gap_cnt  <= gap_n;
      rr_ptr   <= ptr_n;
      gsel     <= gsel_n;
      done     <= done_n;
      aborted  <= aborted_n;
    end
  end

  assign cur_byte = req_data[{gsel, 3'b000} +: 8];
  assign tx_valid = (state == SEND);
  assign tx_data  = tx_valid ? {(^cur_byte) ^ PAR_INV, cur_byte} : 9'd0;
  assign tx_sof   = tx_valid && (byte_idx == 4'd0);
  assign tx_eof   = tx_valid && (byte_idx == LAST_IDX);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Directed bench for frame_tx_scheduler: reset, full frames, parity,
// round-robin order and gap length, back-pressure, abort and mid-frame reset.
module tb_frame_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset, abort, tx_ready;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant, byte_idx, done;
  logic        tx_valid, tx_sof, tx_eof, aborted, busy;
  logic [8:0]  tx_data;
  logic [3:0]  o_grant, o_byte_idx, o_done;
  logic        o_tx_valid, o_tx_sof, o_tx_eof, o_aborted, o_busy;
  logic [8:0]  o_tx_data;

  logic        mode;    // 0: every byte = cbyte, 1: byte = {lane, index}
  logic [7:0]  cbyte;
  int          n_tests = 0;
  int          n_fail  = 0;

  frame_tx_scheduler u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .abort(abort),
    .grant(grant), .byte_idx(byte_idx), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof), .done(done),
    .aborted(aborted), .busy(busy)
  );

  frame_tx_scheduler #(.ODD_PARITY(1)) u_odd (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .abort(abort),
    .grant(o_grant), .byte_idx(o_byte_idx), .tx_valid(o_tx_valid), .tx_ready(tx_ready),
    .tx_data(o_tx_data), .tx_sof(o_tx_sof), .tx_eof(o_tx_eof), .done(o_done),
    .aborted(o_aborted), .busy(o_busy)
  );

  always #5 clk = ~clk;

  // Requester data sources answer the presented byte address.
  always_comb begin
    req_data = 32'd0;
    for (int l = 0; l < 4; l++)
      req_data[8*l +: 8] = mode ? {4'(l), byte_idx} : cbyte;
  end

  function automatic logic [7:0] src(input int lane, input int k);
    logic [3:0] ln, kn;
    ln = 4'(lane);
    kn = 4'(k);
    return mode ? {ln, kn} : cbyte;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!tx_valid && n < 50) begin tick(); n++; end
    chk({tag, "_valid_timeout"}, 32'(tx_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  // One complete frame of 16 transfers, optionally stalled 3 cycles at stall_at.
  task automatic run_frame(input logic [3:0] eg, input int lane, input int stall_at);
    logic [7:0] b;
    wait_valid("frame");
    chk("frame_grant", 32'(grant), 32'(eg));
    for (int k = 0; k < 16; k++) begin
      b = src(lane, k);
      if (k == stall_at) begin
        tx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_data", 32'(tx_data), 32'({^b, b}));
          chk("stall_idx", 32'(byte_idx), 32'(k));
          chk("stall_valid", 32'(tx_valid), 32'd1);
        end
        tx_ready = 1'b1;
      end
      chk("beat_data", 32'(tx_data), 32'({^b, b}));
      chk("beat_data_odd", 32'(o_tx_data), 32'({~^b, b}));
      chk("beat_idx", 32'(byte_idx), 32'(k));
      chk("beat_sof", 32'(tx_sof), 32'(k == 0));
      chk("beat_eof", 32'(tx_eof), 32'(k == 15));
      tick();
    end
    chk("frame_done", 32'(done), 32'(eg));
    chk("frame_grant_clr", 32'(grant), 32'd0);
    chk("frame_valid_clr", 32'(tx_valid), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_idx"}, 32'(byte_idx), 32'd0);
    chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_sof_eof"}, 32'({tx_sof, tx_eof}), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_aborted"}, 32'(aborted), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int g, n;
    reset = 1'b1; req = 4'd0; abort = 1'b0; tx_ready = 1'b1;
    mode = 1'b0; cbyte = 8'hA5;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // 16 beats of 0xA5 from requester 0, done one cycle after last beat
    req = 4'b0001;
    tick();
    chk("first_latency_valid", 32'(tx_valid), 32'd1);
    run_frame(4'b0001, 0, -1);
    chk("a5_busy_gap", 32'(busy), 32'd1);
    req = 4'd0;
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    wait_idle("a5");

    // Parity: 0x07 gives 0x107 even, 0x007 odd
    cbyte = 8'h07; req = 4'b0010;
    wait_valid("par");
    chk("par_even", 32'(tx_data), 32'h107);
    chk("par_odd", 32'(o_tx_data), 32'h007);
    run_frame(4'b0010, 1, -1);
    req = 4'd0;
    wait_idle("par");

    // Round-robin from requester 0 after reset, 2 gap cycles between frames
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 1'b1; req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      run_frame(4'b0001 << (f % 4), f % 4, -1);
      if (f < 4) begin
        g = 0; n = 0;
        while (!tx_valid && n < 20) begin
          if (busy) g++;
          tick(); n++;
        end
        chk("rr_gap_cycles", 32'(g), 32'd2);
      end else begin
        req = 4'd0;
      end
    end
    wait_idle("rr");

    // Back-pressure at byte 5 for three cycles
    req = 4'b0001;
    run_frame(4'b0001, 0, 5);
    req = 4'd0;
    wait_idle("stall");

    // Abort at byte 7 on requester 2; requester 3 is next
    req = 4'b1100;
    wait_valid("abort");
    chk("abort_grant", 32'(grant), 32'b0100);
    repeat (7) tick();
    chk("abort_idx", 32'(byte_idx), 32'd7);
    chk("abort_data", 32'(tx_data), 32'({^src(2, 7), src(2, 7)}));
    abort = 1'b1;
    tick();
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_grant_clr", 32'(grant), 32'd0);
    chk("abort_valid_clr", 32'(tx_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    tick();
    chk("abort_pulse_end", 32'(aborted), 32'd0);
    tick();
    chk("abort_in_idle", 32'(aborted), 32'd0);
    abort = 1'b0;
    wait_valid("abort_next");
    chk("abort_next_grant", 32'(grant), 32'b1000);
    chk("abort_outside_send", 32'(aborted), 32'd0);

    // Reset at byte 10 drops everything at once
    repeat (10) tick();
    chk("rst_mid_idx", 32'(byte_idx), 32'd10);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    req = 4'b0100;
    reset = 1'b0;
    chk("rst_rel_done", 32'(done), 32'd0);
    chk("rst_rel_aborted", 32'(aborted), 32'd0);
    wait_valid("rst_rel");
    chk("rst_rel_grant", 32'(grant), 32'b0100);
    chk("rst_rel_sof", 32'(tx_sof), 32'd1);
    req = 4'd0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_tx_scheduler.md
FRAME_TX_SCHEDULER -- requirements
Module: frame_tx_scheduler

Interface
REQ-001 Parameter FRAME_LEN, default 16, bytes per frame (range 2..16).
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles between frames (range 0..15).
REQ-003 Parameter ODD_PARITY, default 0, 0 = even parity bit, 1 = odd parity bit.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  4  per-requester frame request, level, held until matching done.
REQ-007 req_data  input  32  byte from requester i on bits [8i+7:8i], addressed by byte_idx.
REQ-008 abort  input  1  terminate current frame, sampled in SEND only.
REQ-009 grant  output  4  one-hot granted requester, zero when no frame active.
REQ-010 byte_idx  output  4  byte address presented to granted requester.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  downstream accepts tx_data when high with tx_valid.
REQ-013 tx_data  output  9  {parity, byte}, byte in [7:0].
REQ-014 tx_sof / tx_eof  output  1 each  high with tx_valid on first / last byte.
REQ-015 done  output  4  one-cycle pulse on bit i when requester i's frame fully accepted.
REQ-016 aborted  output  1  one-cycle pulse when a frame is terminated by abort.
REQ-017 busy  output  1  high in SEND and GAP.

Function
REQ-018 FSM states IDLE, SEND, GAP; encoding free.
REQ-019 IDLE: tx_valid=0, grant=0; if any req bit set, winner chosen round-robin, next state SEND, byte_idx=0, grant registered one-hot to winner.
REQ-020 Round-robin: search starts at (last granted + 1) mod 4; after reset search starts at requester 0.
REQ-021 SEND: tx_valid=1 every cycle; tx_data[7:0] = req_data byte of granted lane at byte_idx (combinational mux).
REQ-022 tx_data[8] = XOR of tx_data[7:0] when ODD_PARITY=0, its inverse when ODD_PARITY=1.
REQ-023 Handshake: byte transferred only on tx_valid && tx_ready; tx_data, byte_idx held stable while tx_ready=0.
REQ-024 On transfer with byte_idx < FRAME_LEN-1: byte_idx increments next cycle.
REQ-025 On transfer with byte_idx = FRAME_LEN-1: done[winner] pulses next cycle, grant clears, byte_idx returns to 0, state to GAP (IDLE if GAP_CYCLES=0).
REQ-026 GAP: tx_valid=0, grant=0, counts GAP_CYCLES cycles then IDLE; requests ignored until IDLE.
REQ-027 abort in SEND (with or without simultaneous transfer) takes priority: aborted pulses next cycle, no done, grant clears, state GAP; round-robin pointer still advances past aborted requester.
REQ-028 abort outside SEND has no effect.
REQ-029 req of granted lane dropping mid-frame is ignored; frame completes.
REQ-030 Minimum frame duration FRAME_LEN cycles with tx_ready tied high; first tx_valid one cycle after req seen in IDLE.

Reset
REQ-031 While reset high and on release: state IDLE, grant=0, byte_idx=0, tx_valid=0, tx_sof=0, tx_eof=0, done=0, aborted=0, busy=0, rr pointer = requester 0 first.
REQ-032 Reset asserted mid-frame discards the frame immediately; no done or aborted pulse.

Verification
REQ-033 req=0001, all bytes 0xA5, tx_ready=1 -> 16 beats tx_data=0x0A5, sof on beat 0, eof on beat 15, done=0001 one cycle after beat 15.
REQ-034 Byte 0x07, ODD_PARITY=0 -> tx_data=0x107; ODD_PARITY=1 -> 0x007.
REQ-035 req=1111 held -> grants 0001,0010,0100,1000,0001 in order, each separated by 2 idle cycles (GAP_CYCLES=2).
REQ-036 tx_ready low 3 cycles at byte_idx=5 -> tx_data and byte_idx hold, no byte skipped or duplicated, frame still 16 transfers.
REQ-037 abort at byte_idx=7 on requester 2 -> aborted pulse, done=0000, next grant goes to requester 3 if requesting.
REQ-038 reset at byte_idx=10 -> all outputs zero immediately; after release req=0100 granted first-search from requester 0 order.
